// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO arbiter: register addresses, widths and the transfer FSM states.
package mmio_pkg;

    localparam logic [15:0] LED_ADDR  = 16'hC000;
    localparam logic [15:0] SW_ADDR   = 16'hC001;
    localparam logic [15:0] XCNT_ADDR = 16'hC002;

    localparam int unsigned IO_W = 10;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StResp
    } state_t;

    function automatic logic [15:0] zext_io(input logic [IO_W-1:0] v);
        return {6'h00, v};
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous level inputs; all stages clear on reset.
module sync_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of a tiny MMIO block (LED, switches, transfer counter).
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m0_we,
    input  logic        m0_re,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_re,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    input  logic [9:0]  sw_in,
    output logic [9:0]  ledr
);

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            gnt_q, gnt_d;
    logic            win;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            re_q, re_d;
    logic [15:0]     rdata_q, rdata_d;
    logic [15:0]     read_val;
    logic [IO_W-1:0] led_q, led_d;
    logic [15:0]     xcnt_q;
    logic [IO_W-1:0] sw_sync;
    logic            unused_wdata;

    sync_ff #(
        .WIDTH  (IO_W),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_in),
        .q     (sw_sync)
    );

    // Only the LED register takes write data; the upper bits are deliberately dropped.
    assign unused_wdata = ^wdata_q[15:IO_W];

    always_comb begin
        unique case (addr_q)
            LED_ADDR:  read_val = zext_io(led_q);
            SW_ADDR:   read_val = zext_io(sw_sync);
            XCNT_ADDR: read_val = xcnt_q;
            default:   read_val = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        win     = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    // Contention goes to the pointer; a lone requester wins outright.
                    win     = (m0_req && m1_req) ? ptr_q : m1_req;
                    gnt_d   = win;
                    ptr_d   = ~win;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    we_d    = win ? m1_we    : m0_we;
                    re_d    = win ? m1_re    : m0_re;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (we_q) begin
                    rdata_d = 16'h0000;
                    if (addr_q == LED_ADDR) begin
                        led_d = wdata_q[IO_W-1:0];
                    end
                end else if (re_q) begin
                    rdata_d = read_val;
                end else begin
                    rdata_d = 16'h0000;
                end
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
        end
    end

    // Counted on the edge leaving RESP so a read of XCNT sees the pre-increment value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xcnt_q <= '0;
        end else if (state_q == StResp) begin
            xcnt_q <= xcnt_q + 16'd1;
        end
    end

    always_comb begin
        m0_ack   = (state_q == StResp) && !gnt_q;
        m1_ack   = (state_q == StResp) && gnt_q;
        m0_rdata = m0_ack ? rdata_q : 16'h0000;
        m1_rdata = m1_ack ? rdata_q : 16'h0000;
        ledr     = led_q;
    end

endmodule
